// File: rtl/timer_irq.sv
// timer_irq: memory-mapped 64-bit machine timer (prescaled mtime, mtimecmp, registered interrupt flag).
// Define TIMER_AUTO_RELOAD_EN to add the PERIOD register and hardware reload of mtimecmp.
`ifndef INT_BUS
`define INT_BUS 3:0
`endif
`ifndef INT_NONE
`define INT_NONE 4'h0
`endif
`ifndef INT_TIMER
`define INT_TIMER 4'h7
`endif

module timer_irq #(
  parameter int unsigned ADDR_W       = 5,
  parameter logic [7:0]  RST_PRESCALE = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic [`INT_BUS]   int_flag_o
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MT_LO  = 3'd1;
  localparam logic [2:0] REG_MT_HI  = 3'd2;
  localparam logic [2:0] REG_CMP_LO = 3'd3;
  localparam logic [2:0] REG_CMP_HI = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_PERIOD = 3'd6;

  logic [2:0]  sel_s;
  logic        unused_s;
  logic [31:0] rd_val_s;

  logic        en_q, en_d, irq_en_q, irq_en_d;
  logic [7:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, pend_q, pend_d;
  logic [`INT_BUS] int_flag_q, int_flag_d;
  logic [31:0] period_q, period_d;

  assign sel_s    = addr_i[4:2];
  assign unused_s = ^addr_i[1:0];

  // Register read mux on current (pre-write) state
  always_comb begin
    rd_val_s = 32'd0;
    case (sel_s)
      REG_CTRL:   rd_val_s = {16'd0, prescale_q, 6'd0, irq_en_q, en_q};
      REG_MT_LO:  rd_val_s = mtime_q[31:0];
      REG_MT_HI:  rd_val_s = shadow_q;
      REG_CMP_LO: rd_val_s = mtimecmp_q[31:0];
      REG_CMP_HI: rd_val_s = mtimecmp_q[63:32];
      REG_STATUS: rd_val_s = {31'd0, pend_q};
`ifdef TIMER_AUTO_RELOAD_EN
      REG_PERIOD: rd_val_s = period_q;
`else
      REG_PERIOD: rd_val_s = 32'd0;
`endif
      default:    rd_val_s = 32'd0;
    endcase
  end

  // Next-state: prescaler, compare, reload, then software writes (writes win)
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    rvalid_d   = re_i;
    period_d   = period_q;
    pend_d     = (mtime_q >= mtimecmp_q);
    int_flag_d = (pend_q && irq_en_q) ? `INT_TIMER : `INT_NONE;

    if (en_q) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = 8'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d  = pcnt_q + 8'd1;
      end
    end else begin
      pcnt_d = pcnt_q;
    end

`ifdef TIMER_AUTO_RELOAD_EN
    // Reload on the edge where pend goes 0->1 so each match yields one pulse
    if (pend_d && !pend_q && (period_q != 32'd0)) begin
      mtimecmp_d = mtimecmp_q + {32'd0, period_q};
    end else begin
      mtimecmp_d = mtimecmp_q;
    end
`endif

    case ({re_i, sel_s})
      {1'b1, REG_MT_LO}: begin
        rdata_d  = rd_val_s;
        shadow_d = mtime_q[63:32];
      end
      {1'b1, REG_CTRL}, {1'b1, REG_MT_HI}, {1'b1, REG_CMP_LO}, {1'b1, REG_CMP_HI},
      {1'b1, REG_STATUS}, {1'b1, REG_PERIOD}, {1'b1, 3'd7}: rdata_d = rd_val_s;
      default: rdata_d = rdata_q;
    endcase

    case ({we_i, sel_s})
      {1'b1, REG_CTRL}: begin
        en_d       = wdata_i[0];
        irq_en_d   = wdata_i[1];
        prescale_d = wdata_i[15:8];
        pcnt_d     = 8'd0;
      end
      {1'b1, REG_MT_LO}:  mtime_d    = {mtime_q[63:32], wdata_i};
      {1'b1, REG_MT_HI}:  mtime_d    = {wdata_i, mtime_q[31:0]};
      {1'b1, REG_CMP_LO}: mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
      {1'b1, REG_CMP_HI}: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
`ifdef TIMER_AUTO_RELOAD_EN
      {1'b1, REG_PERIOD}: period_d   = wdata_i;
`endif
      default: period_d = period_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= RST_PRESCALE;
      pcnt_q     <= 8'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q   <= 32'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      pend_q     <= 1'b0;
      int_flag_q <= `INT_NONE;
      period_q   <= 32'd0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      pend_q     <= pend_d;
      int_flag_q <= int_flag_d;
      period_q   <= period_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign int_flag_o = int_flag_q;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios plus random bus traffic against a
// transaction-level model of the timer's register and interrupt rules.
`timescale 1ns/1ps
`ifndef INT_BUS
`define INT_BUS 3:0
`endif
`ifndef INT_NONE
`define INT_NONE 4'h0
`endif
`ifndef INT_TIMER
`define INT_TIMER 4'h7
`endif

module tb_timer_irq;
  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic [`INT_BUS] int_flag_o;

  int tests = 0;
  int fails = 0;

  timer_irq #(.ADDR_W(5), .RST_PRESCALE(8'd0)) dut (
    .clk(clk), .rst(rst), .we_i(we), .re_i(re), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .int_flag_o(int_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en, irq;
    logic [7:0]  ps, pcnt;
    logic [63:0] mt, cmp;
    logic [31:0] sh, period, rdata;
    logic        rvalid, pend;
    logic [3:0]  flag;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t reset_state();
    mstate_t s;
    s = '0;
    s.cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    s.flag = `INT_NONE;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [2:0] a);
    case (a)
      3'd0: return {16'd0, s.ps, 6'd0, s.irq, s.en};
      3'd1: return s.mt[31:0];
      3'd2: return s.sh;
      3'd3: return s.cmp[31:0];
      3'd4: return s.cmp[63:32];
      3'd5: return {31'd0, s.pend};
`ifdef TIMER_AUTO_RELOAD_EN
      3'd6: return s.period;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer described as: reads see old state, compare/flag lag one stage each,
  // mtime advances once per (PRESCALE+1) enabled cycles, software writes override everything.
  function automatic mstate_t step(input mstate_t s, input logic w, input logic r,
                                   input logic [2:0] a, input logic [31:0] d);
    mstate_t n;
    n = s;
    n.rvalid = r;
    if (r) n.rdata = model_read(s, a);
    if (r && a == 3'd1) n.sh = s.mt[63:32];
    n.flag = (s.pend && s.irq) ? `INT_TIMER : `INT_NONE;
    n.pend = (s.mt >= s.cmp);
`ifdef TIMER_AUTO_RELOAD_EN
    if (n.pend && !s.pend && s.period != 32'd0) n.cmp = s.cmp + 64'(s.period);
`endif
    if (s.en) begin
      if (s.pcnt == s.ps) begin
        n.mt = s.mt + 64'd1;
        n.pcnt = 8'd0;
      end else begin
        n.pcnt = s.pcnt + 8'd1;
      end
    end
    if (w) begin
      case (a)
        3'd0: begin n.en = d[0]; n.irq = d[1]; n.ps = d[15:8]; n.pcnt = 8'd0; end
        3'd1: n.mt  = {s.mt[63:32], d};
        3'd2: n.mt  = {d, s.mt[31:0]};
        3'd3: n.cmp = {n.cmp[63:32], d};
        3'd4: n.cmp = {d, n.cmp[31:0]};
`ifdef TIMER_AUTO_RELOAD_EN
        3'd6: n.period = d;
`endif
        default: n.period = n.period;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ms <= reset_state();
    else     ms <= step(ms, we, re, addr[4:2], wdata);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("rvalid", 64'(rvalid_o), 64'(ms.rvalid));
      chk("int_flag", 64'(int_flag_o), 64'(ms.flag));
      chk("rdata", 64'(rdata_o), 64'(ms.rdata));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] d);
    we = 1'b1; addr = {s, 2'($urandom_range(0, 3))}; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, output logic [31:0] d);
    re = 1'b1; addr = {s, 2'($urandom_range(0, 3))};
    @(negedge clk);
    re = 1'b0;
    d = rdata_o;
  endtask

  task automatic wait_flag(input logic [3:0] val, input int bound, output int n);
    n = -1;
    for (int i = 0; i < bound && n < 0; i++) begin
      if (int_flag_o == val) n = i;
      else @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d, d2, m;
    int first;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 5'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Get an interrupt going, then reset mid-count
    wr(3'd4, 32'd0); wr(3'd3, 32'd5); wr(3'd0, 32'h0000_0003);
    idle(12);
    chk("pre_rst_flag", 64'(int_flag_o), 64'(`INT_TIMER));
    #3 rst = 1'b1;
    #1 chk("rst_async_flag", 64'(int_flag_o), 64'(`INT_NONE));
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      rd(3'(s), d);
      chk("rst_read", 64'(d), (s == 3 || s == 4) ? 64'hFFFF_FFFF : 64'd0);
    end

    // Prescaler: PRESCALE=3 gives one tick per 4 cycles
    wr(3'd0, 32'h0000_0301);
    idle(40);
    rd(3'd1, d);
    chk("prescale3_lo", 64'(d >= 32'd9 && d <= 32'd11), 64'd1);
    wr(3'd0, 32'h0000_0001);
    rd(3'd1, d);
    rd(3'd1, d2);
    chk("prescale0_step", 64'(d2 - d), 64'd1);

    // Match at 20: flag two cycles after mtime reaches 20
    wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd2, 32'd0);
    wr(3'd4, 32'd0); wr(3'd3, 32'd20); wr(3'd0, 32'h0000_0003);
    wait_flag(`INT_TIMER, 60, first);
    chk("match_latency", 64'(first), 64'd22);
    rd(3'd1, d);
    chk("match_mtime", 64'(d), 64'd22);
    wr(3'd0, 32'h0000_0001);
    idle(3);
    chk("irq_dis_flag", 64'(int_flag_o), 64'(`INT_NONE));
    rd(3'd5, d);
    chk("irq_dis_pend", 64'(d), 64'd1);

    // Clear by moving mtimecmp ahead
    wr(3'd0, 32'h0000_0003);
    idle(2);
    chk("clear_pre", 64'(int_flag_o), 64'(`INT_TIMER));
    rd(3'd1, m);
    wr(3'd3, m + 32'd100);
    chk("clear_c0", 64'(int_flag_o), 64'(`INT_TIMER));
    idle(1);
    chk("clear_c1", 64'(int_flag_o), 64'(`INT_TIMER));
    idle(1);
    chk("clear_c2", 64'(int_flag_o), 64'(`INT_NONE));

    // Atomic 64-bit read across the 32-bit carry
    wr(3'd0, 32'd0); wr(3'd2, 32'd0); wr(3'd1, 32'hFFFF_FFFE); wr(3'd0, 32'h0000_0001);
    rd(3'd1, d); rd(3'd2, d2);
    chk("atomic_lo", 64'(d), 64'hFFFF_FFFE);
    chk("atomic_hi", 64'(d2), 64'd0);
    rd(3'd1, d); rd(3'd2, d2);
    chk("atomic_lo2", 64'(d), 64'd0);
    chk("atomic_hi2", 64'(d2), 64'd1);

`ifdef TIMER_AUTO_RELOAD_EN
    // Periodic reload every 50 ticks
    wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd2, 32'd0);
    wr(3'd4, 32'd0); wr(3'd3, 32'd50); wr(3'd6, 32'd50); wr(3'd0, 32'h0000_0003);
    for (int k = 0; k < 3; k++) begin
      wait_flag(`INT_TIMER, 200, first);
      chk("reload_seen", 64'(first >= 0), 64'd1);
      rd(3'd1, m); rd(3'd3, d);
      chk("reload_cmp", 64'(d), 64'(50 * (k + 2)));
      chk("reload_mtime", 64'(m >= 32'(50 * (k + 1)) && m <= 32'(50 * (k + 1) + 6)), 64'd1);
      wait_flag(`INT_NONE, 10, first);
    end
`endif

    // Random bus traffic, checked each cycle by the compare process
    wr(3'd0, 32'd0);
    for (int i = 0; i < 600; i++) begin
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 2) == 0);
      addr  = 5'($urandom_range(0, 31));
      wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom;
      if (addr[4:2] == 3'd0) wdata[15:8] = 8'($urandom_range(0, 3));
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
